manycore_link_resp_credit_to_ready_and: RTL and testbench

- Adapter between a manycore endpoint whose outgoing responses use credit flow control and a standard ready/valid-and manycore link.
- Sits between the host/IO endpoint and the manycore array link.
- Forward (request) traffic passes through combinationally in both directions.
- Outgoing responses are buffered in a small FIFO, and one credit is returned per response drained onto the ready/valid-and link.

---
 rtl/manycore_link_resp_credit_to_ready_and_pkg.sv | 51 +++++
 rtl/manycore_link_resp_credit_to_ready_and_resp_fifo.sv | 66 ++++++
 rtl/manycore_link_resp_credit_to_ready_and.sv | 104 ++++++++++
 tb/tb_manycore_link_resp_credit_to_ready_and.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/manycore_link_resp_credit_to_ready_and_pkg.sv
// Shared types and width helpers for the response credit to ready/valid-and link adapter.
// Optional simulation checks in the adapter are enabled by defining CREDIT_ADAPTER_CHECK_EN.
package manycore_link_resp_credit_to_ready_and_pkg;

  // Request packet: address + data + source and destination cords.
  function automatic int fwd_pkt_width(input int addr_w, input int data_w,
                                       input int x_cord_w, input int y_cord_w);
    return addr_w + data_w + 2 * (x_cord_w + y_cord_w);
  endfunction

  // Response packet: 2-bit type + data + destination cords.
  function automatic int rev_pkt_width(input int data_w, input int x_cord_w, input int y_cord_w);
    return 2 + data_w + x_cord_w + y_cord_w;
  endfunction

  function automatic int ptr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  function automatic int cnt_width(input int els);
    return $clog2(els + 1);
  endfunction

  localparam int default_addr_width   = 20;
  localparam int default_data_width   = 32;
  localparam int default_x_cord_width = 3;
  localparam int default_y_cord_width = 3;

  localparam int default_fwd_pkt_width = fwd_pkt_width(default_addr_width, default_data_width,
                                                       default_x_cord_width, default_y_cord_width);
  localparam int default_rev_pkt_width = rev_pkt_width(default_data_width,
                                                       default_x_cord_width, default_y_cord_width);

  typedef struct packed {
    logic                             v;
    logic                             ready_and_rev;
    logic [default_fwd_pkt_width-1:0] data;
  } fwd_link_t;

  typedef struct packed {
    logic                             v;
    logic                             ready_and_rev;
    logic [default_rev_pkt_width-1:0] data;
  } rev_link_t;

  typedef struct packed {
    fwd_link_t fwd;
    rev_link_t rev;
  } link_sif_t;

endpackage

// File: rtl/manycore_link_resp_credit_to_ready_and_resp_fifo.sv
// Circular-buffer response FIFO with arbitrary (non power-of-2) depth and an occupancy count.
// The caller guarantees v_i is never asserted while full without a same-cycle yumi_i.
module manycore_link_resp_credit_to_ready_and_resp_fifo
  import manycore_link_resp_credit_to_ready_and_pkg::*;
#(
  parameter  int width_p  = 40,
  parameter  int els_p    = 3,
  localparam int ptr_w_lp = ptr_width(els_p),
  localparam int cnt_w_lp = cnt_width(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_rd_ptr;
  logic [ptr_w_lp-1:0] r_wr_ptr;
  logic [cnt_w_lp-1:0] r_count;
  logic [cnt_w_lp-1:0] w_count_next;
  logic                w_pop;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop = yumi_i & (r_count != '0);

  always_comb begin
    // NOTE: default first so every path assigns w_count_next; otherwise a latch is inferred.
    w_count_next = r_count;
    case ({v_i, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (v_i)   r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= w_count_next;
    end
  end

  // NOTE: the storage array has no reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk_i) begin
    if (v_i) r_mem[r_wr_ptr] <= data_i;
  end

  assign v_o     = (r_count != '0);
  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: rtl/manycore_link_resp_credit_to_ready_and.sv
// Adapter from a credit-based response endpoint to a ready/valid-and manycore link.
// Define CREDIT_ADAPTER_CHECK_EN for simulation checks on overflow and X on the response valid.
module manycore_link_resp_credit_to_ready_and
  import manycore_link_resp_credit_to_ready_and_pkg::*;
#(
  parameter  int fwd_pkt_width_p = default_fwd_pkt_width,
  parameter  int rev_pkt_width_p = default_rev_pkt_width,
  parameter  int fifo_els_p      = 3,
  localparam int link_width_lp   = (fwd_pkt_width_p + 2) + (rev_pkt_width_p + 2)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [link_width_lp-1:0] credit_link_sif_i,
  output logic [link_width_lp-1:0] credit_link_sif_o,
  input  logic [link_width_lp-1:0] ready_and_link_sif_i,
  output logic [link_width_lp-1:0] ready_and_link_sif_o
);

  localparam int cnt_w_lp = cnt_width(fifo_els_p);

  typedef struct packed {
    logic                       v;
    logic                       ready_and_rev;
    logic [fwd_pkt_width_p-1:0] data;
  } fwd_sif_t;

  typedef struct packed {
    logic                       v;
    logic                       ready_and_rev;
    logic [rev_pkt_width_p-1:0] data;
  } rev_sif_t;

  typedef struct packed {
    fwd_sif_t fwd;
    rev_sif_t rev;
  } sif_t;

  sif_t                       w_credit_in;
  sif_t                       w_credit_out;
  sif_t                       w_ra_in;
  sif_t                       w_ra_out;
  logic                       w_fifo_v;
  logic [rev_pkt_width_p-1:0] w_fifo_data;
  logic [cnt_w_lp-1:0]        w_count;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_push;
  logic                       r_credit;

  assign w_credit_in = credit_link_sif_i;
  assign w_ra_in     = ready_and_link_sif_i;

  // The whole fwd channel, ready bit included, crosses unchanged in both directions.
  assign w_ra_out.fwd     = w_credit_in.fwd;
  assign w_credit_out.fwd = w_ra_in.fwd;

  assign w_credit_out.rev.v             = w_ra_in.rev.v;
  assign w_credit_out.rev.data          = w_ra_in.rev.data;
  assign w_credit_out.rev.ready_and_rev = r_credit;

  assign w_ra_out.rev.v             = w_fifo_v;
  assign w_ra_out.rev.data          = w_fifo_data;
  assign w_ra_out.rev.ready_and_rev = w_credit_in.rev.ready_and_rev;

  assign w_full = (w_count == cnt_w_lp'(fifo_els_p));
  assign w_pop  = w_fifo_v & w_ra_in.rev.ready_and_rev;
  // A push into a full FIFO without a same-cycle pop is dropped to keep pointers coherent.
  assign w_push = w_credit_in.rev.v & (~w_full | w_pop);

  manycore_link_resp_credit_to_ready_and_resp_fifo #(
    .width_p (rev_pkt_width_p),
    .els_p   (fifo_els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .v_i     (w_push),
    .data_i  (w_credit_in.rev.data),
    .v_o     (w_fifo_v),
    .data_o  (w_fifo_data),
    .yumi_i  (w_pop),
    .count_o (w_count)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_credit <= 1'b0;
    else           r_credit <= w_pop;
  end

`ifdef CREDIT_ADAPTER_CHECK_EN
  always @(posedge clk_i) begin
    if (reset_ni) begin
      if ($isunknown(w_credit_in.rev.v))
        $error("%m: X on credit_link_sif_i.rev.v");
      else if (w_credit_in.rev.v && w_full && !w_pop)
        $error("%m: response push while FIFO full, credit overflow");
    end
  end
`else
`endif

  assign credit_link_sif_o    = w_credit_out;
  assign ready_and_link_sif_o = w_ra_out;

endmodule

// File: tb/tb_manycore_link_resp_credit_to_ready_and.sv
// Directed bench: fwd/rev passthrough, response FIFO ordering, credit timing, overflow and mid-stream reset.
module tb_manycore_link_resp_credit_to_ready_and;
  import manycore_link_resp_credit_to_ready_and_pkg::*;

  localparam int ELS = 3;
`ifdef CREDIT_ADAPTER_CHECK_EN
  localparam int EXP_CREDITS = 9;
`else
  localparam int EXP_CREDITS = 13;
`endif

  logic      clk;
  logic      reset_ni;
  link_sif_t credit_i, credit_o, ra_i, ra_o;

  int        n_vec = 0;
  int        n_err = 0;
  int        n_credit_seen = 0;
  logic [default_rev_pkt_width-1:0] q[$];
  logic      exp_credit = 1'b0;
  logic      m_pop;

  manycore_link_resp_credit_to_ready_and #(
    .fifo_els_p(ELS)
  ) u_dut (
    .clk_i               (clk),
    .reset_ni            (reset_ni),
    .credit_link_sif_i   (credit_i),
    .credit_link_sif_o   (credit_o),
    .ready_and_link_sif_i(ra_i),
    .ready_and_link_sif_o(ra_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard at the falling edge: compare outputs, then account for the coming rising edge.
  always @(negedge clk) begin
    if (!reset_ni) begin
      q.delete();
      exp_credit = 1'b0;
      check("rst_rev_v", 64'(ra_o.rev.v), 64'd0);
      check("rst_credit", 64'(credit_o.rev.ready_and_rev), 64'd0);
    end else begin
      if (credit_o.rev.ready_and_rev === 1'b1) n_credit_seen++;
      check("credit", 64'(credit_o.rev.ready_and_rev), 64'(exp_credit));
      check("rev_v", 64'(ra_o.rev.v), 64'(q.size() != 0));
      m_pop = 1'b0;
      if (q.size() != 0) begin
        check("rev_data", 64'(ra_o.rev.data), 64'(q[0]));
        m_pop = ra_i.rev.ready_and_rev;
      end
      if (m_pop) void'(q.pop_front());
      if (credit_i.rev.v && q.size() < ELS) q.push_back(credit_i.rev.data);
      exp_credit = m_pop;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [default_rev_pkt_width-1:0] d);
    credit_i.rev.v    = 1'b1;
    credit_i.rev.data = d;
    cyc();
    credit_i.rev.v    = 1'b0;
  endtask

  initial begin
    credit_i = '0;
    ra_i     = '0;
    reset_ni = 1'b0;
    repeat (5) cyc();
    reset_ni = 1'b1;
    #1 check("rst_count", 64'(u_dut.w_count), 64'd0);
    cyc();

    // Fwd passthrough, endpoint to network and back.
    credit_i.fwd.v             = 1'b1;
    credit_i.fwd.data          = 64'h1234_5678;
    credit_i.fwd.ready_and_rev = 1'b1;
    #1;
    check("fwd_out_v", 64'(ra_o.fwd.v), 64'd1);
    check("fwd_out_data", ra_o.fwd.data, 64'h1234_5678);
    check("fwd_out_rdy", 64'(ra_o.fwd.ready_and_rev), 64'd1);
    ra_i.fwd.v             = 1'b1;
    ra_i.fwd.data          = 64'hCAFE_F00D_0000_0001;
    ra_i.fwd.ready_and_rev = 1'b1;
    #1;
    check("fwd_in_v", 64'(credit_o.fwd.v), 64'd1);
    check("fwd_in_data", credit_o.fwd.data, 64'hCAFE_F00D_0000_0001);
    check("fwd_in_rdy1", 64'(credit_o.fwd.ready_and_rev), 64'd1);
    cyc();
    ra_i.fwd.ready_and_rev     = 1'b0;
    credit_i.fwd.ready_and_rev = 1'b0;
    #1;
    check("fwd_in_rdy0", 64'(credit_o.fwd.ready_and_rev), 64'd0);
    check("fwd_out_rdy0", 64'(ra_o.fwd.ready_and_rev), 64'd0);
    cyc();

    // Rev passthrough, network to endpoint.
    ra_i.rev.v                 = 1'b1;
    ra_i.rev.data              = 40'h77_0000_0077;
    credit_i.rev.ready_and_rev = 1'b1;
    #1;
    check("rev_in_v", 64'(credit_o.rev.v), 64'd1);
    check("rev_in_data", 64'(credit_o.rev.data), 64'h77_0000_0077);
    check("rev_in_rdy", 64'(ra_o.rev.ready_and_rev), 64'd1);
    cyc();
    ra_i.rev.v = 1'b0;

    // Single response with the network ready.
    ra_i.rev.ready_and_rev = 1'b1;
    push(40'hA5);
    repeat (4) cyc();

    // Fill to depth under backpressure, then drain.
    ra_i.rev.ready_and_rev = 1'b0;
    push(40'h1); push(40'h2); push(40'h3);
    cyc();
    check("full_count", 64'(u_dut.w_count), 64'd3);
    ra_i.rev.ready_and_rev = 1'b1;
    repeat (5) cyc();

    // Push while full and popping in the same cycle.
    ra_i.rev.ready_and_rev = 1'b0;
    push(40'h1); push(40'h2); push(40'h3);
    ra_i.rev.ready_and_rev = 1'b1;
    push(40'h4);
    repeat (5) cyc();

`ifndef CREDIT_ADAPTER_CHECK_EN
    // Overflowing push is dropped; later traffic stays in order.
    ra_i.rev.ready_and_rev = 1'b0;
    push(40'h11); push(40'h12); push(40'h13); push(40'h14);
    check("ovf_count", 64'(u_dut.w_count), 64'd3);
    ra_i.rev.ready_and_rev = 1'b1;
    push(40'h15);
    repeat (5) cyc();
`endif

    // Mid-stream reset discards queued responses without credits.
    ra_i.rev.ready_and_rev = 1'b0;
    push(40'h21); push(40'h22);
    reset_ni = 1'b0;
    #1 check("midrst_count", 64'(u_dut.w_count), 64'd0);
    cyc(); cyc();
    reset_ni = 1'b1;
    ra_i.rev.ready_and_rev = 1'b1;
    repeat (3) cyc();
    push(40'h33);
    repeat (4) cyc();

    check("credit_total", 64'(n_credit_seen), 64'(EXP_CREDITS));
    check("end_count", 64'(u_dut.w_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
